// File: rtl/jpeg_blk_arbiter.sv
// jpeg_blk_arbiter
// Round-robin block scheduler in front of the shared JPEG quantization stage.
// A winning producer keeps the grant for a whole block of BLK_LEN coefficients;
// every forwarded beat carries its source, in-block index and an end-of-block flag.
// Optional stall watchdog: define JPEG_ARB_WDOG_EN to build it (default: absent,
// wdog_err tied low and a stalled grant is held indefinitely).
module jpeg_blk_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 12,
  parameter int BLK_LEN  = 64,
  parameter int WDOG_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [2:0]           out_src,
  output logic [5:0]           out_idx,
  output logic                 out_eob,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 wdog_err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(BLK_LEN);

  // Reject configurations the index/source fields cannot represent.
  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("jpeg_blk_arbiter: NREQ must be 2..8");
  end
  if (BLK_LEN < 2 || BLK_LEN > 64 || (BLK_LEN & (BLK_LEN - 1)) != 0) begin : g_chk_blk
    $error("jpeg_blk_arbiter: BLK_LEN must be a power of two in 2..64");
  end
  if (WDOG_CYC < 1) begin : g_chk_wdog
    $error("jpeg_blk_arbiter: WDOG_CYC must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   next_ptr;
  logic [CW-1:0]   beat_cnt;

  logic [NREQ-1:0] rot_valid;
  logic [GW-1:0]   pick_off;
  logic [GW:0]     pick_sum;
  logic [GW-1:0]   pick;
  logic            pick_found;

  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            can_load;
  logic            xfer;
  logic            last_beat;
  logic            wdog_fire;
  logic [5:0]      idx_ext;
  logic [2:0]      src_ext;

  // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then rotate the offset back.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick_off   = '0;
    rot_valid  = NREQ'({req_valid, req_valid} >> rr_ptr);
    for (int j = 0; j < NREQ; j++) begin
      if (!pick_found && rot_valid[j]) begin
        pick_found = 1'b1;
        pick_off   = GW'(j);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    pick     = (pick_sum >= (GW+1)'(NREQ)) ? GW'(pick_sum - (GW+1)'(NREQ)) : GW'(pick_sum);
  end

  // Select the granted requester's data and valid.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant == GW'(j)) begin
        sel_data  = req_data[j*DW +: DW];
        sel_valid = req_valid[j];
      end
    end
  end

  // Only the granted requester sees ready, and only while the output register can take a beat.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = (state == BURST) && (grant == GW'(j)) && can_load;
    end
  end

  // Zero-extend the narrow counters onto the fixed-width output fields.
  always_comb begin
    idx_ext           = '0;
    idx_ext[CW-1:0]   = beat_cnt;
    src_ext           = '0;
    src_ext[GW-1:0]   = grant;
  end

  assign can_load  = !out_valid || out_ready;
  assign xfer      = (state == BURST) && sel_valid && can_load;
  assign last_beat = (beat_cnt == CW'(BLK_LEN - 1));
  assign next_ptr  = (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign busy      = (state == BURST);

`ifdef JPEG_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] wdog_cnt;

  // Fires on the cycle that would make the stall run WDOG_CYC cycles long.
  assign wdog_fire = (state == BURST) && !sel_valid && (wdog_cnt == WW'(WDOG_CYC - 1));

  // Count consecutive stalled cycles of the granted requester; latch the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state != BURST || sel_valid || wdog_fire) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Arbitration FSM plus the output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the output payload is reset too, so a partial block never leaks out after reset.
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_idx   <= '0;
      out_eob   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_src   <= src_ext;
        out_idx   <= idx_ext;
        out_eob   <= last_beat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (wdog_fire) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jpeg_blk_arbiter.md
Name: jpeg_blk_arbiter

Overview:
- Round-robin scheduler that shares one downstream JPEG coefficient datapath (quantizer/compare chain) between NREQ block producers.
- Grants are held for a whole 8x8 block: BLK_LEN coefficients are streamed from the winning requester before re-arbitration.
- Stamps each beat with source ID, in-block index and an end-of-block flag.
- Sits between the DCT/zig-zag producers and the shared quantization stage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 12, coefficient width in bits.
- BLK_LEN, 64, coefficients per block (power of two, 2..64).
- WDOG_CYC, 256, stall limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester coefficient valid.
- req_data  input  NREQ*DW  coefficients; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  per-requester accept.
- out_valid  output  1  output beat valid.
- out_data  output  DW  coefficient.
- out_src  output  3  index of the source requester.
- out_idx  output  6  position in block, 0..BLK_LEN-1.
- out_eob  output  1  high on the beat where out_idx = BLK_LEN-1.
- out_ready  input  1  downstream accept.
- busy  output  1  high in BURST.
- wdog_err  output  1  sticky stall error (optional feature only; otherwise tied 0).

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-low (rst_n).
  - On reset: state = IDLE, rr_ptr = 0, grant = 0, beat_cnt = 0.
  - On reset: out_valid, out_data, out_src, out_idx, out_eob, busy, wdog_err and req_ready all = 0.
- States:
  - IDLE: no grant. If any req_valid is high, pick the first requester with valid high, searching from rr_ptr upward modulo NREQ. Latch it as grant, clear beat_cnt and enter BURST next cycle. Arbitration latency is 1 cycle. req_ready is all-zero in IDLE.
  - BURST: req_ready[grant] = !out_valid || out_ready. All other req_ready bits are 0.
- Beat transfer:
  - A beat transfers when req_valid[grant] && req_ready[grant].
  - On transfer the output register loads: out_data = that requester's slice, out_src = grant, out_idx = beat_cnt, out_eob = (beat_cnt == BLK_LEN-1), out_valid = 1. beat_cnt then increments.
  - Output beat appears 1 cycle after acceptance.
  - If out_ready && out_valid and there is no new transfer, out_valid drops to 0.
  - out_* fields hold while out_valid && !out_ready.
- Block completion:
  - On transfer of beat BLK_LEN-1: state = IDLE, rr_ptr = (grant+1) mod NREQ, beat_cnt = 0.
  - The eob beat may still sit in the output register during the following IDLE cycle; it drains normally.
  - Back-to-back blocks therefore have a 1-cycle input bubble.
- Stall rules:
  - If the granted requester drops valid mid-block, the grant is held and no other requester is served.
  - If other requesters raise valid during BURST, they are not served until block end.
  - No req_ready asserts without a grant.
- Simultaneous request from all requesters: service order is strict rotation, e.g. 0,1,2,3,0 from reset.
- Reset mid-block: the partial block is discarded; the bench must see out_valid = 0 immediately (asynchronous).
- busy = (state == BURST).
- out_idx is zero-extended when BLK_LEN < 64.

Optional Feature:
- Macro: JPEG_ARB_WDOG_EN.
- When defined:
  - A counter runs in BURST and counts consecutive cycles with req_valid[grant] = 0. Any transfer clears it.
  - On reaching WDOG_CYC: set wdog_err (sticky until reset), abandon the block and go to IDLE with rr_ptr = grant+1.
  - No eob beat is emitted for the abandoned block. Any beat already in the output register still drains.
- When undefined: no counter is built, wdog_err is constant 0, and the grant is held indefinitely.

Test Plan:
- Single requester: reset; req_valid = 4'b0010, 64 beats with data = idx, out_ready = 1 -> out_src = 1, out_idx 0..63 in order, out_eob only on idx 63, busy falls after beat 63.
- All requesters contend: req_valid = 4'b1111 continuously -> blocks granted in order 0,1,2,3,0, each exactly 64 beats, 1-cycle bubble between blocks.
- Backpressure: out_ready toggles 1010... during a block -> no beat lost or duplicated, out_* stable while out_valid && !out_ready, all 64 indices delivered.
- Mid-block dropout: requester 2 deasserts valid at beat 30 for 10 cycles while requester 3 is valid -> requester 3 gets no req_ready until requester 2's beat 63 completes.
- Async reset mid-block: assert rst_n = 0 at beat 17 -> out_valid, busy and req_ready go 0 without waiting for a clock edge. After release, the next grant starts from requester 0 with out_idx = 0.
- JPEG_ARB_WDOG_EN with WDOG_CYC = 16: granted requester stalls 16 cycles at beat 5 -> wdog_err = 1 and stays 1; state returns to IDLE; no eob beat; the next requester is granted.
